// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: register ALU results for write-back and run loads to completion.
// Loads stall the pipeline until data memory deasserts MEM_BUSYWAIT, then the aligned and
// extended value is written back. Bad loads (misaligned, illegal FUNCT3) and loads that
// wait too long raise a one-cycle ERR pulse and produce no write.
module mem_wb_stage #(
  parameter logic [7:0] WAIT_LIMIT = 8'd255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        VALID,
  input  logic [31:0] ALU_RESULT,
  input  logic [4:0]  RD,
  input  logic        REG_WRITE,
  input  logic        MEM_READ,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT,
  output logic [31:0] WB_DATA,
  output logic [4:0]  WB_ADDR,
  output logic        WB_EN,
  output logic        STALL,
  output logic        ERR
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StWait = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] wb_data_d;
  logic [4:0]  wb_addr_d;
  logic        wb_en_d;
  logic        err_d;

  logic        acc_bad;
  logic [31:0] load_val;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [8:0]  cnt_next;

  // Classify an incoming load as misaligned or illegal before it is accepted.
  always_comb begin
    acc_bad = 1'b0;
    case (FUNCT3)
      3'b000, 3'b100: acc_bad = 1'b0;
      3'b001, 3'b101: acc_bad = ALU_RESULT[0];
      3'b010:         acc_bad = (ALU_RESULT[1:0] != 2'b00);
      default:        acc_bad = 1'b1;
    endcase
  end

  // Align the memory word using the captured offset and extend per the captured load type.
  always_comb begin
    byte_v = 8'h00;
    case (off_q)
      2'd0:    byte_v = MEM_READDATA[7:0];
      2'd1:    byte_v = MEM_READDATA[15:8];
      2'd2:    byte_v = MEM_READDATA[23:16];
      default: byte_v = MEM_READDATA[31:24];
    endcase
    half_v   = off_q[1] ? MEM_READDATA[31:16] : MEM_READDATA[15:0];
    load_val = MEM_READDATA;
    case (funct3_q)
      3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_val = {{16{half_v[15]}}, half_v};
      3'b100:  load_val = {24'h000000, byte_v};
      3'b101:  load_val = {16'h0000, half_v};
      default: load_val = MEM_READDATA;
    endcase
  end

  // Stall while a load is outstanding, including the cycle a good load is accepted.
  always_comb begin
    STALL = (state_q == StWait) ||
            ((state_q == StIdle) && VALID && MEM_READ && !acc_bad);
  end

  // Next-state, counter and write-back decisions.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    funct3_d  = funct3_q;
    off_d     = off_q;
    wb_data_d = WB_DATA;
    wb_addr_d = WB_ADDR;
    wb_en_d   = 1'b0;
    err_d     = 1'b0;
    // Widened so a limit of 255 cannot wrap the compare.
    cnt_next  = {1'b0, cnt_q} + 9'd1;
    case (state_q)
      StIdle: begin
        if (VALID) begin
          if (MEM_READ) begin
            if (acc_bad) begin
              err_d = 1'b1;
            end else begin
              state_d  = StWait;
              cnt_d    = 8'd0;
              rd_d     = RD;
              funct3_d = FUNCT3;
              off_d    = ALU_RESULT[1:0];
            end
          end else if (REG_WRITE && (RD != 5'd0)) begin
            wb_en_d   = 1'b1;
            wb_data_d = ALU_RESULT;
            wb_addr_d = RD;
          end
        end
      end
      default: begin
        // Data arriving on the limit edge wins over the timeout.
        if (!MEM_BUSYWAIT) begin
          state_d = StIdle;
          if (rd_q != 5'd0) begin
            wb_en_d   = 1'b1;
            wb_data_d = load_val;
            wb_addr_d = rd_q;
          end
        end else if (cnt_next >= {1'b0, WAIT_LIMIT}) begin
          state_d = StIdle;
          cnt_d   = cnt_next[7:0];
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_next[7:0];
        end
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= StIdle;
      cnt_q    <= 8'd0;
      rd_q     <= 5'd0;
      funct3_q <= 3'd0;
      off_q    <= 2'd0;
      WB_DATA  <= 32'd0;
      WB_ADDR  <= 5'd0;
      WB_EN    <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      WB_DATA  <= wb_data_d;
      WB_ADDR  <= wb_addr_d;
      WB_EN    <= wb_en_d;
      ERR      <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed writes/loads push expected write-backs and
// error pulses into queues; a monitor pops and compares whenever WB_EN or ERR is seen.
module tb_mem_wb_stage;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        VALID;
  logic [31:0] ALU_RESULT;
  logic [4:0]  RD;
  logic        REG_WRITE;
  logic        MEM_READ;
  logic [2:0]  FUNCT3;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;
  logic [31:0] WB_DATA;
  logic [4:0]  WB_ADDR;
  logic        WB_EN;
  logic        STALL;
  logic        ERR;

  int checks   = 0;
  int failures = 0;

  logic [36:0] exp_wr[$];
  int          exp_err[$];

  mem_wb_stage #(.WAIT_LIMIT(8'd4)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .VALID        (VALID),
    .ALU_RESULT   (ALU_RESULT),
    .RD           (RD),
    .REG_WRITE    (REG_WRITE),
    .MEM_READ     (MEM_READ),
    .FUNCT3       (FUNCT3),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT),
    .WB_DATA      (WB_DATA),
    .WB_ADDR      (WB_ADDR),
    .WB_EN        (WB_EN),
    .STALL        (STALL),
    .ERR          (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every write-back and error pulse must match the head of its queue.
  always @(negedge CLK) begin
    logic [36:0] e;
    if (WB_EN === 1'b1) begin
      checks++;
      if (exp_wr.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got addr=%0d data=0x%08h, expected none", WB_ADDR, WB_DATA);
      end else begin
        e = exp_wr.pop_front();
        if ({WB_ADDR, WB_DATA} !== e) begin
          failures++;
          $display("FAIL write: got addr=%0d data=0x%08h, expected addr=%0d data=0x%08h",
                   WB_ADDR, WB_DATA, e[36:32], e[31:0]);
        end
      end
    end
    if (ERR === 1'b1) begin
      checks++;
      if (exp_err.size() == 0) begin
        failures++;
        $display("FAIL unexpected_err: got ERR=1, expected 0");
      end else begin
        void'(exp_err.pop_front());
      end
    end
  end

  task automatic idle_inputs();
    VALID = 1'b0; REG_WRITE = 1'b0; MEM_READ = 1'b0; RD = 5'd0;
    FUNCT3 = 3'd0; ALU_RESULT = 32'd0; MEM_BUSYWAIT = 1'b0;
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic alu_op(input logic [4:0] rd, input logic [31:0] val);
    VALID = 1'b1; REG_WRITE = 1'b1; MEM_READ = 1'b0; RD = rd; ALU_RESULT = val;
    if (rd != 5'd0) exp_wr.push_back({rd, val});
    tick(1);
    idle_inputs();
  endtask

  // Issues a load; memory is busy for the first 'busy' cycles starting at acceptance.
  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input int busy, output int stalls);
    int i;
    VALID = 1'b1; MEM_READ = 1'b1; REG_WRITE = 1'b1; RD = rd; FUNCT3 = f3;
    ALU_RESULT = addr; MEM_READDATA = rdata;
    stalls = 0;
    for (i = 0; i < 20; i++) begin
      MEM_BUSYWAIT = (i < busy);
      #1;
      if (STALL !== 1'b1) break;
      stalls++;
      tick(1);
      if (i == 0) begin
        // Upstream contents are don't-care while stalled; scramble them.
        VALID = 1'b0; RD = 5'd31; FUNCT3 = 3'b111; ALU_RESULT = 32'hFFFF_FFFF;
      end
    end
    if (i == 20) begin
      checks++; failures++;
      $display("FAIL stall_bound: got STALL stuck for 20 cycles, expected release");
    end
    if (i == 0) tick(1);
    idle_inputs();
    tick(1);
  endtask

  initial begin
    int st;
    idle_inputs();
    MEM_READDATA = 32'd0;
    RESET = 1'b1;
    tick(2);
    check("rst_wb_en", {31'd0, WB_EN}, 32'd0);
    check("rst_err", {31'd0, ERR}, 32'd0);
    check("rst_data", WB_DATA, 32'd0);
    check("rst_addr", {27'd0, WB_ADDR}, 32'd0);
    check("rst_stall", {31'd0, STALL}, 32'd0);
    RESET = 1'b0;
    tick(1);

    // ALU write-back with one-cycle latency, then hold.
    alu_op(5'd5, 32'h0000_1234);
    check("alu_wb_en", {31'd0, WB_EN}, 32'd1);
    tick(1);
    check("alu_wb_en_drop", {31'd0, WB_EN}, 32'd0);
    check("alu_hold_data", WB_DATA, 32'h0000_1234);
    check("alu_hold_addr", {27'd0, WB_ADDR}, 32'd5);
    alu_op(5'd0, 32'hAAAA_5555);
    // Valid with neither write nor read: no write-back.
    VALID = 1'b1; REG_WRITE = 1'b0; RD = 5'd6; ALU_RESULT = 32'h1;
    tick(1);
    idle_inputs();
    tick(1);

    exp_wr.push_back({5'd7, 32'hFFFF_FF80});
    do_load(5'd7, 3'b000, 32'h0000_0103, 32'h80FF_0000, 3, st);
    check("lb_stalls", st, 32'd4);
    exp_wr.push_back({5'd8, 32'h0000_BEEF});
    do_load(5'd8, 3'b101, 32'h0000_0012, 32'hBEEF_0000, 1, st);
    check("lhu_stalls", st, 32'd2);
    exp_wr.push_back({5'd9, 32'hFFFF_8001});
    do_load(5'd9, 3'b001, 32'h0000_0020, 32'h1234_8001, 0, st);
    exp_wr.push_back({5'd10, 32'h0000_00AB});
    do_load(5'd10, 3'b100, 32'h0000_0001, 32'h0000_AB00, 0, st);
    exp_wr.push_back({5'd11, 32'hDEAD_BEEF});
    do_load(5'd11, 3'b010, 32'h0000_0000, 32'hDEAD_BEEF, 2, st);
    // Data on the same edge the counter reaches the limit completes the load.
    exp_wr.push_back({5'd12, 32'h1234_5678});
    do_load(5'd12, 3'b010, 32'h0000_0004, 32'h1234_5678, 4, st);
    check("limit_edge_stalls", st, 32'd5);

    // Bad loads: no stall, one ERR each.
    exp_err.push_back(1);
    do_load(5'd13, 3'b010, 32'h0000_0001, 32'h5555_5555, 0, st);
    check("lw_misalign_stalls", st, 32'd0);
    exp_err.push_back(2);
    do_load(5'd13, 3'b001, 32'h0000_0003, 32'h5555_5555, 0, st);
    check("lh_misalign_stalls", st, 32'd0);
    exp_err.push_back(3);
    do_load(5'd13, 3'b011, 32'h0000_0000, 32'h5555_5555, 0, st);
    check("illegal_stalls", st, 32'd0);

    // Timeout: acceptance plus four WAIT cycles.
    exp_err.push_back(4);
    do_load(5'd14, 3'b010, 32'h0000_0000, 32'h7777_7777, 99, st);
    check("timeout_stalls", st, 32'd5);

    // Reset during the second WAIT cycle abandons the load.
    VALID = 1'b1; MEM_READ = 1'b1; REG_WRITE = 1'b1; RD = 5'd15; FUNCT3 = 3'b010;
    ALU_RESULT = 32'h0; MEM_READDATA = 32'hCAFE_F00D; MEM_BUSYWAIT = 1'b1;
    tick(1);
    VALID = 1'b0;
    tick(1);
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    MEM_BUSYWAIT = 1'b0;
    check("mid_rst_stall", {31'd0, STALL}, 32'd0);
    check("mid_rst_wb_en", {31'd0, WB_EN}, 32'd0);
    check("mid_rst_data", WB_DATA, 32'd0);
    check("mid_rst_addr", {27'd0, WB_ADDR}, 32'd0);
    check("mid_rst_err", {31'd0, ERR}, 32'd0);
    idle_inputs();
    tick(3);
    check("post_rst_stall", {31'd0, STALL}, 32'd0);

    // Load to x0 still stalls and completes but never writes.
    do_load(5'd0, 3'b010, 32'h0000_0000, 32'h1111_1111, 2, st);
    check("rd0_stalls", st, 32'd3);
    tick(2);

    check("writes_pending", exp_wr.size(), 32'd0);
    check("errs_pending", exp_err.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 The block SHALL have parameter WAIT_LIMIT, default 8'd255, the maximum number of WAIT cycles before a load is abandoned.
REQ-002 The block SHALL have port CLK, input, 1, the rising-edge clock.
REQ-003 The block SHALL have port RESET, input, 1, the synchronous active-high reset.
REQ-004 The block SHALL have port VALID, input, 1, the EX/MEM instruction-present flag.
REQ-005 The block SHALL have port ALU_RESULT, input, 32, the ALU result or load address.
REQ-006 The block SHALL have port RD, input, 5, the destination register index.
REQ-007 The block SHALL have port REG_WRITE, input, 1, the instruction-writes-rd flag.
REQ-008 The block SHALL have port MEM_READ, input, 1, the instruction-is-load flag.
REQ-009 The block SHALL have port FUNCT3, input, 3, the load type.
REQ-010 The block SHALL have port MEM_READDATA, input, 32, the word read from data memory.
REQ-011 The block SHALL have port MEM_BUSYWAIT, input, 1, the data-memory-not-ready flag.
REQ-012 The block SHALL have port WB_DATA, output, 32, the data driven to the register file IN port.
REQ-013 The block SHALL have port WB_ADDR, output, 5, the index driven to the register file INADDRESS port.
REQ-014 The block SHALL have port WB_EN, output, 1, the signal driven to the register file WRITEENABLE port.
REQ-015 The block SHALL have port STALL, output, 1, the pipeline freeze request to the upstream stages.
REQ-016 The block SHALL have port ERR, output, 1, a one-cycle pulse flagging a misaligned, illegal or timed-out load.
REQ-017 The block SHALL use one clock, with CLK and RESET named as above; reset SHALL be synchronous and active-high.

Function
REQ-018 The block SHALL implement FSM states IDLE and WAIT, with all state, counter and output registers updating only on the CLK rising edge.
REQ-019 In IDLE, with VALID=1, MEM_READ=0 and REG_WRITE=1, the block SHALL at the next edge set WB_DATA=ALU_RESULT, WB_ADDR=RD and WB_EN=1, giving 1-cycle latency.
REQ-020 In IDLE, with VALID=1 and MEM_READ=1, the block SHALL capture RD, FUNCT3 and ALU_RESULT[1:0], clear the wait counter, and go to WAIT.
REQ-021 STALL SHALL be combinational: 1 when state=WAIT, or when state=IDLE with VALID=1 and MEM_READ=1; 0 otherwise.
REQ-022 In WAIT with MEM_BUSYWAIT=0, the block SHALL at that edge load the aligned and extended data into WB_DATA, set WB_EN=1 and WB_ADDR to the captured RD, and return to IDLE.
REQ-023 In WAIT with MEM_BUSYWAIT=1, the block SHALL increment the counter; when the counter equals WAIT_LIMIT, the block SHALL pulse ERR, keep WB_EN=0 and return to IDLE.
REQ-024 Alignment SHALL use offset = ALU_RESULT[1:0]: byte = MEM_READDATA[8*off+7:8*off]; half = MEM_READDATA[16*off[1]+15:16*off[1]].
REQ-025 FUNCT3 decode: 000 LB sign-extends byte; 001 LH sign-extends half; 010 LW passes the word; 100 LBU zero-extends byte; 101 LHU zero-extends half.
REQ-026 Misalignment (LH/LHU with off[0]=1, LW with off!=0) or an illegal FUNCT3 (011, 110, 111) SHALL be detected at load acceptance: no WAIT entry, STALL=0, ERR pulsed at the next edge, WB_EN=0.
REQ-027 WB_EN SHALL be a single-cycle pulse; in any cycle not granting a write, WB_EN=0 while WB_DATA and WB_ADDR hold their last values.
REQ-028 RD=0 SHALL never produce WB_EN=1; the load path SHALL still stall and complete normally.
REQ-029 VALID=0, or VALID=1 with REG_WRITE=0 and MEM_READ=0, SHALL produce WB_EN=0 at the next edge.
REQ-030 Inputs other than MEM_BUSYWAIT and MEM_READDATA SHALL be ignored while in WAIT, since upstream holds them under STALL.
REQ-031 MEM_BUSYWAIT=0 and counter=WAIT_LIMIT on the same edge SHALL be treated as completion, not timeout.

Reset
REQ-032 With RESET=1 at an edge, the block SHALL enter IDLE and clear the counter, WB_DATA=0, WB_ADDR=0, WB_EN=0 and ERR=0, overriding every other condition, including a load in progress.
REQ-033 After a reset, STALL SHALL read 0 until a new VALID load arrives, and an abandoned load SHALL produce no write.

Verification
REQ-034 ALU op: VALID=1, REG_WRITE=1, RD=5, ALU_RESULT=0x0000_1234 -> next cycle WB_EN=1, WB_ADDR=5, WB_DATA=0x0000_1234; one cycle later WB_EN=0.
REQ-035 LB: ALU_RESULT=0x...03, FUNCT3=000, BUSYWAIT high for 3 cycles, MEM_READDATA=0x80FF_0000 -> STALL high for 4 cycles, then WB_DATA=0xFFFF_FF80, WB_EN=1.
REQ-036 LHU with off=2 and READDATA=0xBEEF_0000 -> WB_DATA=0x0000_BEEF; LW with off=1 -> ERR pulse, no STALL, WB_EN=0.
REQ-037 Timeout with WAIT_LIMIT=4 and BUSYWAIT held at 1 -> ERR pulses on the 4th WAIT edge, STALL drops, WB_EN stays 0.
REQ-038 RESET=1 on the 2nd WAIT cycle -> next edge all outputs 0, STALL=0, no later write; a load to RD=0 completes with WB_EN=0.
